// File: rtl/alu_writeback.sv
// alu_writeback: result-select and register-writeback stage behind the ALU.
// Captures the ALU result bundle, picks the result named by the opcode and
// drives the register-file write port through a valid/ready handshake.
// Optional feature macro: MUL_HI_WB_EN (multiply written as two 16-bit beats).
module alu_writeback #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        select,
   input  logic [ADDR_W-1:0] rdst1,
   input  logic [ADDR_W-1:0] rdst2,
   input  logic [223:0]      res_bus,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [15:0]       wb_data,
   output logic              flag_z,
   output logic              flag_n,
   output logic              flag_ill
);

`ifdef MUL_HI_WB_EN
   typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_t;
`else
   typedef enum logic [1:0] {IDLE, WR_LO} state_t;
`endif

   state_t      state;
   logic [31:0] result_q;
   logic        is_mul_q;
   logic [31:0] sel_res;
   logic        legal;
   logic        accept;
   logic        final_beat;
   logic        done;
   logic        done_z;
   logic        done_n;

`ifdef MUL_HI_WB_EN
   logic [ADDR_W-1:0] rdst2_q;
`else
   // rdst2, the product high half and the multiply marker have no consumer here
   logic unused_mul_hi;
   assign unused_mul_hi = ^{rdst2, result_q[31:16], is_mul_q};
`endif

   assign legal  = (select <= 6'd12);
   assign accept = in_valid && in_ready;

   // Pick the result named by the opcode; the 32-bit product shifts later slots up by one
   always_comb begin
      sel_res = '0;
      case (select)
         6'd0:    sel_res[15:0] = res_bus[15:0];
         6'd1:    sel_res[15:0] = res_bus[31:16];
         6'd2:    sel_res[15:0] = res_bus[47:32];
         6'd3:    sel_res       = res_bus[79:48];
         6'd4:    sel_res[15:0] = res_bus[95:80];
         6'd5:    sel_res[15:0] = res_bus[111:96];
         6'd6:    sel_res[15:0] = res_bus[127:112];
         6'd7:    sel_res[15:0] = res_bus[143:128];
         6'd8:    sel_res[15:0] = res_bus[159:144];
         6'd9:    sel_res[15:0] = res_bus[175:160];
         6'd10:   sel_res[15:0] = res_bus[191:176];
         6'd11:   sel_res[15:0] = res_bus[207:192];
         6'd12:   sel_res[15:0] = res_bus[223:208];
         default: sel_res       = '0;
      endcase
   end

   // Final-beat detection, completion flags and the combinational accept path
   always_comb begin
`ifdef MUL_HI_WB_EN
      final_beat = ((state == WR_LO) && !is_mul_q) || (state == WR_HI);
      if (is_mul_q) begin
         done_z = (result_q == 32'd0);
         done_n = result_q[31];
      end else begin
         done_z = (result_q[15:0] == 16'd0);
         done_n = result_q[15];
      end
`else
      final_beat = (state == WR_LO);
      done_z     = (result_q[15:0] == 16'd0);
      done_n     = result_q[15];
`endif
      done     = wb_valid && wb_ready && final_beat;
      in_ready = (state == IDLE) || done;
   end

   // Writeback FSM with registered write-port outputs and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         result_q <= '0;
         is_mul_q <= 1'b0;
         wb_valid <= 1'b0;
         wb_addr  <= '0;
         wb_data  <= '0;
         flag_z   <= 1'b0;
         flag_n   <= 1'b0;
         flag_ill <= 1'b0;
`ifdef MUL_HI_WB_EN
         rdst2_q  <= '0;
`endif
      end else begin
         if (done) begin
            flag_z <= done_z;
            flag_n <= done_n;
         end
         if (accept && !legal) begin
            flag_ill <= 1'b1;
         end
         // accept implies IDLE or a completing final beat, so a load overrides both
         if (accept && legal) begin
            state    <= WR_LO;
            result_q <= sel_res;
            is_mul_q <= (select == 6'd3);
            wb_valid <= 1'b1;
            wb_addr  <= rdst1;
            wb_data  <= sel_res[15:0];
`ifdef MUL_HI_WB_EN
            rdst2_q  <= rdst2;
`endif
         end else if (done) begin
            state    <= IDLE;
            wb_valid <= 1'b0;
`ifdef MUL_HI_WB_EN
         end else if ((state == WR_LO) && wb_ready && is_mul_q) begin
            state    <= WR_HI;
            wb_addr  <= rdst2_q;
            wb_data  <= result_q[31:16];
`endif
         end
      end
   end

endmodule
